ex_issue_ctrl: RTL

- Issue controller between decode and the execute stage (alu_core plus its control shift registers).
- Tracks in-flight destination registers in a fixed-latency scoreboard.
- Stalls decode on read-after-write hazards, because the execute pipeline has no forwarding.
- Squashes younger in-flight writes on a branch flush and counts stall cycles.

---
 rtl/ex_issue_ctrl_pkg.sv | 16 +
 rtl/ex_scoreboard.sv | 51 +++++
 rtl/ex_issue_ctrl.sv | 73 +++++++
 3 files changed

// File: rtl/ex_issue_ctrl_pkg.sv
// Shared types and defaults for the execute-stage issue controller.
// Register width matches the existing defines.v value.
package ex_issue_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PIPE_DEPTH_DEF = 6;
  localparam int FLUSH_DEPTH_DEF = 2;
  localparam int CNT_WIDTH_DEF = 16;

  // One in-flight destination: v = 0 marks a bubble or a squashed write.
  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/ex_scoreboard.sv
// Fixed-latency shift-register scoreboard of in-flight destination registers.
// Entry 0 is the youngest; the oldest entry's regfile write completes as it shifts out.
module ex_scoreboard
  import ex_issue_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH  = PIPE_DEPTH_DEF,
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_v,
  input  logic [REG_ADDR_W-1:0] load_rd,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_match,
  output logic                  rs2_match,
  output logic                  busy
);

  sb_entry_t sb_q [PIPE_DEPTH];

  // A flush kills the FLUSH_DEPTH youngest slots of the next state, entry 0 included.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        sb_q[k].v  <= 1'b0;
        sb_q[k].rd <= '0;
      end
    end else begin
      sb_q[0].v  <= load_v && !flush;
      sb_q[0].rd <= load_rd;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        sb_q[k].v  <= sb_q[k-1].v && !(flush && (k < FLUSH_DEPTH));
        sb_q[k].rd <= sb_q[k-1].rd;
      end
    end
  end

  always_comb begin
    rs1_match = 1'b0;
    rs2_match = 1'b0;
    busy      = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      rs1_match = rs1_match | (sb_q[k].v && (sb_q[k].rd == rs1_addr));
      rs2_match = rs2_match | (sb_q[k].v && (sb_q[k].rd == rs2_addr));
      busy      = busy | sb_q[k].v;
    end
  end

endmodule

// File: rtl/ex_issue_ctrl.sv
// Issue controller between decode and execute: RAW stall (no forwarding),
// branch-flush squash of young writes, and a saturating stall-cycle counter.
module ex_issue_ctrl
  import ex_issue_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_W,
  parameter int PIPE_DEPTH     = PIPE_DEPTH_DEF,
  parameter int FLUSH_DEPTH    = FLUSH_DEPTH_DEF,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  output logic                      id_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic                      rs1_used_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic                      rs2_used_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      regwrite_i,
  input  logic                      flush_i,
  output logic                      issue_o,
  output logic                      busy_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

  logic rs1_match;
  logic rs2_match;
  logic hazard_rs1;
  logic hazard_rs2;
  logic load_v;
  logic stall_inc;
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  ex_scoreboard #(
    .PIPE_DEPTH  (PIPE_DEPTH),
    .FLUSH_DEPTH (FLUSH_DEPTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .load_v    (load_v),
    .load_rd   (rd_addr_i),
    .flush     (flush_i),
    .rs1_addr  (rs1_addr_i),
    .rs2_addr  (rs2_addr_i),
    .rs1_match (rs1_match),
    .rs2_match (rs2_match),
    .busy      (busy_o)
  );

  // Handshake: an instruction transfers (issue_o) in any cycle where id_valid_i
  // and id_ready_o are both high; ready never depends on valid, and a stalled
  // instruction must be held stable by decode until it transfers.
  always_comb begin
    hazard_rs1 = rs1_used_i && (rs1_addr_i != '0) && rs1_match;
    hazard_rs2 = rs2_used_i && (rs2_addr_i != '0) && rs2_match;
    id_ready_o = !hazard_rs1 && !hazard_rs2 && !flush_i;
    issue_o    = id_valid_i && id_ready_o;
    load_v     = issue_o && regwrite_i && (rd_addr_i != '0);
    stall_inc  = id_valid_i && !id_ready_o && !flush_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
